// File: rtl/cell_write_scheduler_if.sv
// Shared cell/info types plus the bundle between the converter pop ports,
// the scheduler and the packet-buffer write port.
package cell_write_scheduler_pkg;
  localparam int NBR_OF_PORTS     = 4;
  localparam int BUFFER_ADDRESSES = 32;
  localparam int PORT_W           = $clog2(NBR_OF_PORTS);
  localparam int ADDR_W           = $clog2(BUFFER_ADDRESSES);

  typedef struct packed {
    logic [6:0] length;
    logic       dataPresent;
    logic       startOfFrame;
    logic       endOfFrame;
    logic       error;
  } info_type;

  typedef struct packed {
    info_type            info;
    logic [PORT_W-1:0]   port;
    logic [ADDR_W-1:0]   address;
  } cell_queue_type;
endpackage

// Handshake: a converter hands over its head cell when pop[p] is high at a clock
// edge; the buffer takes the registered cell on any edge where writeEnable is
// high and writeRejected is low, otherwise the same cell is presented again.
interface cell_write_scheduler_if
  import cell_write_scheduler_pkg::*;
#(
  parameter int nbrOfPorts     = 4,
  parameter int parrallelWidth = 512,
  parameter int addressWidth   = 5
) ();
  localparam int portWidth = $clog2(nbrOfPorts);

  logic [nbrOfPorts-1:0]                     empty;
  logic [nbrOfPorts-1:0][parrallelWidth-1:0] popData;
  info_type [nbrOfPorts-1:0]                 info;
  logic [nbrOfPorts-1:0]                     pop;

  logic                      writeRejected;
  logic [addressWidth-1:0]   writeAddress;
  logic                      writeEnable;
  logic [parrallelWidth-1:0] writeData;
  info_type                  writeInfo;
  logic [portWidth-1:0]      writePort;
  logic                      wroteCell;
  cell_queue_type            writtenCell;
  logic                      droppedCell;
  logic [15:0]               droppedFrames;

  modport master (
    input  empty, popData, info, writeRejected, writeAddress,
    output pop, writeEnable, writeData, writeInfo, writePort,
           wroteCell, writtenCell, droppedCell, droppedFrames
  );

  modport slave (
    output empty, popData, info, writeRejected, writeAddress,
    input  pop, writeEnable, writeData, writeInfo, writePort,
           wroteCell, writtenCell, droppedCell, droppedFrames
  );
endinterface

// File: rtl/cell_write_scheduler.sv
// Round-robin arbiter feeding one registered cell into the packet-buffer write
// port, with bounded retry and frame-tail discard after a dropped cell.
module cell_write_scheduler
  import cell_write_scheduler_pkg::*;
#(
  parameter int nbrOfPorts      = NBR_OF_PORTS,
  parameter int parrallelWidth  = 512,
  parameter int bufferAddresses = BUFFER_ADDRESSES,
  parameter int addressWidth    = $clog2(bufferAddresses),
  parameter int maxRetries      = 4
) (
  input logic                   clk,
  input logic                   rst,
  cell_write_scheduler_if.master bus
);
  localparam int PW = $clog2(nbrOfPorts);
  localparam int RW = $clog2(maxRetries + 1);

  // The shared struct types are sized from the package constants.
  if (nbrOfPorts < 2 || maxRetries < 1 || nbrOfPorts != NBR_OF_PORTS ||
      addressWidth != ADDR_W || (2 ** addressWidth) < bufferAddresses) begin : g_bad_params
    $error("cell_write_scheduler: unsupported parameter combination");
  end

  typedef enum logic {S_EMPTY, S_HOLD} state_e;

  state_e                    state_q, state_d;
  logic [parrallelWidth-1:0] data_q, data_d;
  info_type                  info_q, info_d;
  logic [PW-1:0]             port_q, port_d;
  logic [PW-1:0]             last_grant_q, last_grant_d;
  logic [RW-1:0]             retry_cnt_q, retry_cnt_d;
  logic [nbrOfPorts-1:0]     discard_q, discard_d;
  logic [15:0]               dropped_frames_q, dropped_frames_d;

  logic                  accept, reject, drop, slot_free;
  logic                  grant_valid;
  logic [PW-1:0]         grant_port;
  logic [PW-1:0]         idx;
  logic [nbrOfPorts-1:0] eligible, drain, grant_pop;

  always_comb begin
    accept    = (state_q == S_HOLD) && !bus.writeRejected;
    reject    = (state_q == S_HOLD) && bus.writeRejected;
    drop      = reject && (retry_cnt_q == RW'(maxRetries - 1));
    slot_free = (state_q == S_EMPTY) || accept || drop;

    // A port whose mid-frame cell is dropped this cycle must start draining, not be re-granted.
    for (int p = 0; p < nbrOfPorts; p++) begin
      eligible[p] = !bus.empty[p] && !discard_q[p] &&
                    !(drop && !info_q.endOfFrame && (port_q == PW'(p)));
      drain[p]    = discard_q[p] && !bus.empty[p];
    end

    grant_valid = 1'b0;
    grant_port  = '0;
    idx         = '0;
    for (int i = 1; i <= nbrOfPorts; i++) begin
      idx = PW'((int'(last_grant_q) + i) % nbrOfPorts);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_port  = idx;
      end
    end

    grant_pop = '0;
    if (slot_free && grant_valid) grant_pop[grant_port] = 1'b1;
  end

  always_comb begin
    state_d          = state_q;
    data_d           = data_q;
    info_d           = info_q;
    port_d           = port_q;
    last_grant_d     = last_grant_q;
    retry_cnt_d      = retry_cnt_q;
    discard_d        = discard_q;
    dropped_frames_d = dropped_frames_q;

    if (slot_free) begin
      retry_cnt_d = '0;
      if (grant_valid) begin
        state_d      = S_HOLD;
        data_d       = bus.popData[grant_port];
        info_d       = bus.info[grant_port];
        port_d       = grant_port;
        last_grant_d = grant_port;
      end else begin
        state_d = S_EMPTY;
      end
    end else if (reject) begin
      retry_cnt_d = retry_cnt_q + RW'(1);
    end

    for (int p = 0; p < nbrOfPorts; p++) begin
      if (drain[p] && bus.info[p].endOfFrame) discard_d[p] = 1'b0;
    end
    if (drop && !info_q.endOfFrame) discard_d[port_q] = 1'b1;

    if (drop && (dropped_frames_q != 16'hFFFF)) dropped_frames_d = dropped_frames_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_EMPTY;
      data_q           <= '0;
      info_q           <= '0;
      port_q           <= '0;
      last_grant_q     <= PW'(nbrOfPorts - 1);
      retry_cnt_q      <= '0;
      discard_q        <= '0;
      dropped_frames_q <= '0;
    end else begin
      state_q          <= state_d;
      data_q           <= data_d;
      info_q           <= info_d;
      port_q           <= port_d;
      last_grant_q     <= last_grant_d;
      retry_cnt_q      <= retry_cnt_d;
      discard_q        <= discard_d;
      dropped_frames_q <= dropped_frames_d;
    end
  end

  // Held low in reset so a non-empty converter cannot lose a cell while the slot is cleared.
  assign bus.pop           = rst ? '0 : (drain | grant_pop);
  assign bus.writeEnable   = (state_q == S_HOLD);
  assign bus.writeData     = data_q;
  assign bus.writeInfo     = info_q;
  assign bus.writePort     = port_q;
  assign bus.wroteCell     = accept;
  assign bus.writtenCell   = '{info: info_q, port: port_q, address: bus.writeAddress};
  assign bus.droppedCell   = drop;
  assign bus.droppedFrames = dropped_frames_q;
endmodule

// File: tb/tb_cell_write_scheduler.sv
// Bench for cell_write_scheduler: per-port source queues feed the converters,
// and every accepted write is matched against an expected-cell queue.
module tb_cell_write_scheduler;
  import cell_write_scheduler_pkg::*;

  localparam int NP   = 4;
  localparam int DW   = 512;
  localparam int AW   = 5;
  localparam int PW   = 2;
  localparam int MAXR = 4;
  localparam int EW   = PW + 32;

  typedef struct packed {
    logic [31:0] tag;
    logic        sof;
    logic        eof;
  } src_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cell_write_scheduler_if #(.nbrOfPorts(NP), .parrallelWidth(DW), .addressWidth(AW)) bus ();

  cell_write_scheduler #(
    .nbrOfPorts(NP), .parrallelWidth(DW), .bufferAddresses(32),
    .addressWidth(AW), .maxRetries(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  src_t        src_q[NP][$];
  logic [EW-1:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tag_cnt = 32'h100;
  logic [AW-1:0] addr_cnt;
  logic [EW-1:0] exp_v, got_v;

  // Converter model: head of each source queue is presented; a pop seen at the edge consumes it.
  function automatic void update_drive();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() != 0) begin
        bus.empty[p]   = 1'b0;
        bus.popData[p] = {16{src_q[p][0].tag}};
        bus.info[p]    = '{length: 7'd64, dataPresent: 1'b1, startOfFrame: src_q[p][0].sof,
                           endOfFrame: src_q[p][0].eof, error: 1'b0};
      end else begin
        bus.empty[p]   = 1'b1;
        bus.popData[p] = '0;
        bus.info[p]    = '0;
      end
    end
  endfunction

  initial begin : feeder
    logic [NP-1:0] mask;
    addr_cnt = '0;
    bus.writeAddress = addr_cnt;
    update_drive();
    forever begin
      @(posedge clk);
      mask = bus.pop;
      #1;
      for (int p = 0; p < NP; p++)
        if (mask[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
      addr_cnt = addr_cnt + AW'(3);
      bus.writeAddress = addr_cnt;
      update_drive();
      @(negedge clk);
      #1;
      update_drive();
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.wroteCell) begin
        checks++;
        got_v = {bus.writePort, bus.writeData[31:0]};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got port/tag=%h required none", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v || bus.writeData !== {16{exp_v[31:0]}} ||
              bus.writtenCell.port !== exp_v[EW-1:32] ||
              bus.writtenCell.address !== bus.writeAddress ||
              bus.writtenCell.info.length !== 7'd64) begin
            errors++;
            $display("FAIL write_cell got port/tag=%h addr=%h required port/tag=%h addr=%h",
                     got_v, bus.writtenCell.address, exp_v, bus.writeAddress);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_cell(input int p, input logic sof, input logic eof, input logic expect_write);
    tag_cnt = tag_cnt + 32'd1;
    src_q[p].push_back('{tag: tag_cnt, sof: sof, eof: eof});
    if (expect_write) exp_q.push_back({PW'(p), tag_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.writeRejected = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending writes required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.writeRejected = 1'b0;
    push_cell(0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (bus.writeEnable !== 1'b0 || bus.wroteCell !== 1'b0 || bus.droppedCell !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got we=%b wc=%b dc=%b required 0 0 0",
               bus.writeEnable, bus.wroteCell, bus.droppedCell);
    end
    checks++;
    if (bus.writeData !== '0 || bus.writePort !== '0 || bus.writeInfo !== '0) begin
      errors++;
      $display("FAIL reset_regs got port=%0d data_lo=%h required 0 0", bus.writePort, bus.writeData[31:0]);
    end
    checks++;
    if (bus.pop !== 4'b0000 || bus.droppedFrames !== 16'd0) begin
      errors++;
      $display("FAIL reset_pop got pop=%b frames=%0d required 0000 0", bus.pop, bus.droppedFrames);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < NP; p++) push_cell(p, 1'b1, 1'b1, 1'b1);
    #3;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_pop got %b required 0001", bus.pop);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.wroteCell !== 1'b1) begin
        errors++;
        $display("FAIL rr_stream cycle %0d got wroteCell=%b required 1", k, bus.wroteCell);
      end
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got we=%b required 0", bus.writeEnable);
    end
    wait_drain("rr");
  endtask

  task automatic test_sparse();
    do_reset();
    for (int i = 0; i < 3; i++) push_cell(2, i == 0, i == 2, 1'b1);
    #3;
    checks++;
    if (bus.pop !== 4'b0100 || bus.writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL sparse_first got pop=%b we=%b required 0100 0", bus.pop, bus.writeEnable);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.pop !== 4'b0100 || bus.writeEnable !== 1'b1 || bus.writePort !== 2'd2) begin
        errors++;
        $display("FAIL sparse_cycle%0d got pop=%b we=%b port=%0d required 0100 1 2",
                 k, bus.pop, bus.writeEnable, bus.writePort);
      end
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.pop !== 4'b0000 || bus.writeEnable !== 1'b1 || bus.writePort !== 2'd2) begin
      errors++;
      $display("FAIL sparse_last got pop=%b we=%b port=%0d required 0000 1 2",
               bus.pop, bus.writeEnable, bus.writePort);
    end
    wait_drain("sparse");
  endtask

  task automatic test_retry();
    logic [31:0] tag_a;
    do_reset();
    bus.writeRejected = 1'b1;
    push_cell(1, 1'b1, 1'b0, 1'b1);
    tag_a = tag_cnt;
    push_cell(1, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.writeEnable !== 1'b1 || bus.wroteCell !== 1'b0 || bus.writeData[31:0] !== tag_a ||
          bus.pop !== 4'b0000 || bus.droppedCell !== 1'b0) begin
        errors++;
        $display("FAIL retry_hold%0d got we=%b wc=%b tag=%h pop=%b dc=%b required 1 0 %h 0000 0",
                 k, bus.writeEnable, bus.wroteCell, bus.writeData[31:0], bus.pop, bus.droppedCell, tag_a);
      end
    end
    @(negedge clk);
    #3;
    bus.writeRejected = 1'b0;
    #1;
    checks++;
    if (bus.wroteCell !== 1'b1 || bus.writeData[31:0] !== tag_a || bus.pop !== 4'b0010) begin
      errors++;
      $display("FAIL retry_accept got wc=%b tag=%h pop=%b required 1 %h 0010",
               bus.wroteCell, bus.writeData[31:0], bus.pop, tag_a);
    end
    wait_drain("retry");
  endtask

  task automatic test_drop_drain();
    do_reset();
    bus.writeRejected = 1'b1;
    push_cell(0, 1'b1, 1'b0, 1'b0);
    push_cell(0, 1'b0, 1'b0, 1'b0);
    push_cell(0, 1'b0, 1'b0, 1'b0);
    push_cell(0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.droppedCell !== 1'b0 || bus.writeEnable !== 1'b1) begin
        errors++;
        $display("FAIL drop_reject%0d got dc=%b we=%b required 0 1", k, bus.droppedCell, bus.writeEnable);
      end
    end
    @(negedge clk);
    push_cell(3, 1'b1, 1'b0, 1'b1);
    push_cell(3, 1'b0, 1'b1, 1'b1);
    #3;
    checks++;
    if (bus.droppedCell !== 1'b1 || bus.pop !== 4'b1000) begin
      errors++;
      $display("FAIL drop_pulse got dc=%b pop=%b required 1 1000", bus.droppedCell, bus.pop);
    end
    @(posedge clk);
    #1;
    bus.writeRejected = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #3;
      checks++;
      if (bus.pop[0] !== 1'b1 || bus.droppedFrames !== 16'd1 || bus.droppedCell !== 1'b0) begin
        errors++;
        $display("FAIL drain_pop%0d got pop0=%b frames=%0d dc=%b required 1 1 0",
                 k, bus.pop[0], bus.droppedFrames, bus.droppedCell);
      end
    end
    @(negedge clk);
    #3;
    checks++;
    if (bus.pop[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain_done got pop0=%b required 0", bus.pop[0]);
    end
    @(negedge clk);
    push_cell(0, 1'b1, 1'b1, 1'b1);
    #3;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL drain_regrant got pop=%b required 0001", bus.pop);
    end
    wait_drain("drop");
  endtask

  task automatic test_eof_drop();
    logic [31:0] tag_b;
    do_reset();
    bus.writeRejected = 1'b1;
    push_cell(0, 1'b1, 1'b1, 1'b0);
    push_cell(0, 1'b1, 1'b1, 1'b1);
    tag_b = tag_cnt;
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (bus.droppedCell !== 1'b1 || bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL eof_drop got dc=%b pop=%b required 1 0001", bus.droppedCell, bus.pop);
    end
    @(posedge clk);
    #1;
    bus.writeRejected = 1'b0;
    @(negedge clk);
    #3;
    checks++;
    if (bus.droppedFrames !== 16'd1 || bus.writeEnable !== 1'b1 || bus.writePort !== 2'd0 ||
        bus.writeData[31:0] !== tag_b) begin
      errors++;
      $display("FAIL eof_next got frames=%0d we=%b port=%0d tag=%h required 1 1 0 %h",
               bus.droppedFrames, bus.writeEnable, bus.writePort, bus.writeData[31:0], tag_b);
    end
    wait_drain("eof");
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.writeRejected = 1'b1;
    push_cell(0, 1'b1, 1'b1, 1'b0);
    push_cell(0, 1'b1, 1'b1, 1'b1);
    push_cell(1, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (bus.droppedFrames !== 16'd1 || bus.writeEnable !== 1'b1 || bus.writePort !== 2'd1) begin
      errors++;
      $display("FAIL arst_pre got frames=%0d we=%b port=%0d required 1 1 1",
               bus.droppedFrames, bus.writeEnable, bus.writePort);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.writeEnable !== 1'b0 || bus.pop !== 4'b0000 || bus.droppedFrames !== 16'd0 ||
        bus.wroteCell !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got we=%b pop=%b frames=%0d wc=%b required 0 0000 0 0",
               bus.writeEnable, bus.pop, bus.droppedFrames, bus.wroteCell);
    end
    push_cell(1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.writeRejected = 1'b0;
    #3;
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL arst_first_grant got pop=%b required 0001", bus.pop);
    end
    wait_drain("arst");
  endtask

  initial begin : main
    bus.writeRejected = 1'b0;
    test_reset();
    test_round_robin();
    test_sparse();
    test_retry();
    test_drop_drain();
    test_eof_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cell_write_scheduler.md
Name: cell_write_scheduler

Overview:
- Shares the single packet-buffer write port among the nbrOfPorts serial-to-parallel converters.
- Uses round-robin arbitration and registers the granted cell in one output stage.
- Retries cells the buffer rejects, instead of halting.
- After a bounded number of rejects, discards the rest of the affected frame so the buffer never stores a broken packet.
- Sits between the per-port converter pop interfaces and the buffer/queue manager.

Parameters:
- nbrOfPorts, 4, number of requesting converter ports (≥2).
- parrallelWidth, 512, cell data width in bits.
- bufferAddresses, 32, buffer depth in cells.
- addressWidth, $clog2(bufferAddresses), buffer address width.
- maxRetries, 4, consecutive rejects of one cell before the cell is dropped (≥1).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- empty  input  nbrOfPorts  per-port converter empty flag.
- popData  input  nbrOfPorts x parrallelWidth  per-port head cell data.
- info  input  nbrOfPorts x info_type  per-port head cell info (length, dataPresent, startOfFrame, endOfFrame, error).
- pop  output  nbrOfPorts  per-port pop strobe; combinational from registered state and empty.
- writeRejected  input  1  buffer refuses the current write this cycle.
- writeAddress  input  addressWidth  buffer address for the current write.
- writeEnable  output  1  output stage holds a valid cell.
- writeData  output  parrallelWidth  registered cell data.
- writeInfo  output  info_type  registered cell info.
- writePort  output  $clog2(nbrOfPorts)  source port of the registered cell.
- wroteCell  output  1  cell accepted this cycle (writeEnable & !writeRejected).
- writtenCell  output  cell_queue_type  {info, port, address=writeAddress}; valid when wroteCell.
- droppedCell  output  1  one-cycle pulse when a cell is dropped after maxRetries.
- droppedFrames  output  16  saturating count of frames truncated by drops.

Behaviour:
- Reset (async, rst=1):
  - valid=0, so writeEnable=0, wroteCell=0, droppedCell=0.
  - writeData, writeInfo, writePort cleared to 0; pop=0.
  - retryCnt=0, discard[]=0, droppedFrames=0.
  - lastGrant=nbrOfPorts-1, so port 0 has first priority.
- Load slot: free when valid=0, or when valid=1 and the cell leaves this cycle (accepted or dropped).
- Arbitration (only when the slot is free):
  - Eligible ports: !empty[p] && !discard[p].
  - Search starts at lastGrant+1 and wraps modulo nbrOfPorts; the first eligible port p wins.
  - The scheduler asserts pop[p] that cycle.
  - At the clock edge: data/info captured, writePort=p, valid=1, lastGrant=p, retryCnt=0.
  - Latency: non-empty head to writeEnable is 1 cycle.
  - Back-to-back accepts sustain 1 cell/cycle.
- Accept: valid && !writeRejected. wroteCell=1 combinationally; writtenCell.address=writeAddress that cycle.
- Reject: valid && writeRejected.
  - retryCnt increments; the output stage holds its contents unchanged.
  - writeEnable stays high (retry next cycle).
- Drop: a reject when retryCnt==maxRetries-1.
  - Cell discarded, droppedCell=1, slot freed (a new grant is allowed the same cycle).
  - If the dropped cell has endOfFrame=0, set discard[writePort]. Otherwise only the cell is lost.
  - droppedFrames increments (saturates at 16'hFFFF) on every drop.
- Discard drain:
  - Every port with discard[p]=1 && !empty[p] is popped every cycle, independent of arbitration.
  - Drained cells are never written.
  - Popping a cell with endOfFrame=1 clears discard[p] at the next edge.
  - A discarding port is never granted, including the cycle its flag clears.
- Simultaneous events:
  - Drain pops on other ports coexist with a grant pop.
  - At most one pop per port per cycle.
  - A drop and a new grant to a different port occur in the same cycle.
  - A port that drops a frame-end cell may be re-granted immediately if it wins round-robin.
- No eligible port and slot free: valid goes to 0 at the next edge; pop for grants stays 0.
- Reset mid-operation: the registered cell and discard state are lost, no pops are issued, and arbitration restarts at port 0.

Test Plan:
1. Round-robin fairness. nbrOfPorts=4, all ports continuously non-empty, writeRejected=0 → writePort sequence 0,1,2,3,0,… with wroteCell high every cycle after the first.
2. Sparse request. Only port 2 non-empty for 3 cells → pop[2] on 3 consecutive cycles; writeEnable rises 1 cycle after the first pop; writePort=2 throughout.
3. Retry then accept. Port 1 cell; writeRejected high for 2 cycles, then low → writeData stable for 3 cycles, wroteCell on the 3rd cycle, no pops on port 1 during the retries, droppedCell=0.
4. Drop and drain. maxRetries=4; the SOF cell of a 4-cell frame on port 0 is rejected 4 times:
   - droppedCell pulses on the 4th reject; droppedFrames=1.
   - The next 3 port-0 cells are popped without writeEnable.
   - Port 0 is eligible again after the EOF cell.
   - Port 3 traffic is written meanwhile.
5. Drop of an EOF cell. Rejected maxRetries times → discard not set; the next port-0 frame is granted normally.
6. Async reset mid-retry. rst asserted between clock edges while valid=1 → writeEnable=0, pop=0, and droppedFrames=0 immediately; after release, port 0 is granted first.
